// File: rtl/valurap_step_pkg.sv
// Shared step/dir definitions: decoder FSM encoding, error flag bit positions,
// direction pin polarity and a saturating increment for the FSM phase counter.
package valurap_step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } step_state_e;

  localparam int ERR_SHORT_HIGH = 0;
  localparam int ERR_DIR_CHG    = 1;
  localparam int ERR_EARLY_RISE = 2;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  localparam int STATE_CNT_BITS = 8;

  function automatic logic [STATE_CNT_BITS-1:0] sat_inc_cnt(input logic [STATE_CNT_BITS-1:0] v);
    return (v == {STATE_CNT_BITS{1'b1}}) ? v : v + STATE_CNT_BITS'(1);
  endfunction

endpackage

// File: rtl/step_pin_sync.sv
// Two-flop synchronizer for one asynchronous pin with edge detection. During
// the two cycles after reset prev follows s1 so a pin already high is not a rise.
module step_pin_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       s1_r;
  logic       s2_r;
  logic       prev_r;
  logic [1:0] warm_r;

  // synchronizer chain, edge-history register and post-reset warm-up count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_r   <= 1'b0;
      s2_r   <= 1'b0;
      prev_r <= 1'b0;
      warm_r <= 2'd0;
    end else begin
      s1_r   <= pin;
      s2_r   <= s1_r;
      prev_r <= (warm_r == 2'd2) ? s2_r : s1_r;
      warm_r <= (warm_r == 2'd2) ? warm_r : warm_r + 2'd1;
    end
  end

  assign level = s2_r;
  assign rise  = s2_r & ~prev_r;
  assign fall  = ~s2_r & prev_r;

endmodule

// File: rtl/step_dir_decoder.sv
// Step/dir receiver: position accumulator, pulse-timing FSM with sticky error flags,
// and the optional step-interval counter enabled by STEP_DIR_DECODER_INTERVAL_EN.
module step_dir_decoder
  import valurap_step_pkg::*;
#(
  parameter int POS_BITS = 64,
  parameter int INT_BITS = 32,
  parameter int MIN_HIGH = 4,
  parameter int MIN_LOW  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       step_in,
  input  logic                       dir_in,
  input  logic                       set_pos,
  input  logic signed [POS_BITS-1:0] pos_val,
  input  logic                       clr_err,
  output logic signed [POS_BITS-1:0] position,
  output logic                       step_seen,
  output logic                       dir,
  output logic [INT_BITS-1:0]        interval,
  output logic                       interval_vld,
  output logic [2:0]                 err
);

  localparam logic [STATE_CNT_BITS-1:0] MIN_HIGH_C = STATE_CNT_BITS'(MIN_HIGH);
  localparam logic [STATE_CNT_BITS-1:0] MIN_LOW_C  = STATE_CNT_BITS'(MIN_LOW);

  logic step_lvl_s, step_rise_s, step_fall_s;
  logic dir_lvl_s, dir_rise_s, dir_fall_s;
  logic dir_edges_unused_s;

  step_pin_sync u_step_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (step_in),
    .level   (step_lvl_s),
    .rise    (step_rise_s),
    .fall    (step_fall_s)
  );

  step_pin_sync u_dir_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (dir_in),
    .level   (dir_lvl_s),
    .rise    (dir_rise_s),
    .fall    (dir_fall_s)
  );

  assign dir_edges_unused_s = dir_rise_s | dir_fall_s | step_lvl_s;

  step_state_e                state_r, state_nx_s;
  logic [STATE_CNT_BITS-1:0]  cnt_r, cnt_nx_s, cnt_inc_s;
  logic                       dir_lat_r, dir_lat_nx_s;
  logic [2:0]                 err_set_s;

  assign cnt_inc_s = sat_inc_cnt(cnt_r);

  // pulse-timing FSM: next state, phase counter and error detection
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    dir_lat_nx_s = dir_lat_r;
    err_set_s    = 3'b000;
    case (state_r)
      ST_IDLE: begin
        if (step_rise_s) begin
          state_nx_s   = ST_HIGH;
          cnt_nx_s     = {STATE_CNT_BITS{1'b0}};
          dir_lat_nx_s = dir_lvl_s;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_HIGH: begin
        cnt_nx_s = cnt_inc_s;
        if (dir_lvl_s != dir_lat_r) begin
          err_set_s[ERR_DIR_CHG] = 1'b1;
        end else begin
          err_set_s[ERR_DIR_CHG] = 1'b0;
        end
        if (step_fall_s) begin
          state_nx_s = ST_LOW;
          cnt_nx_s   = {STATE_CNT_BITS{1'b0}};
          err_set_s[ERR_SHORT_HIGH] = (cnt_inc_s < MIN_HIGH_C);
        end else begin
          state_nx_s = ST_HIGH;
        end
      end
      ST_LOW: begin
        cnt_nx_s = cnt_inc_s;
        // a rise landing exactly on the MIN_LOW-th low cycle is still legal
        if (step_rise_s) begin
          state_nx_s   = ST_HIGH;
          cnt_nx_s     = {STATE_CNT_BITS{1'b0}};
          dir_lat_nx_s = dir_lvl_s;
          err_set_s[ERR_EARLY_RISE] = (cnt_inc_s < MIN_LOW_C);
        end else if (cnt_inc_s >= MIN_LOW_C) begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = {STATE_CNT_BITS{1'b0}};
        end else begin
          state_nx_s = ST_LOW;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = {STATE_CNT_BITS{1'b0}};
      end
    endcase
  end

  logic signed [POS_BITS-1:0] position_r;
  logic                       step_seen_r;
  logic                       dir_r;
  logic [2:0]                 err_r;

  // FSM state plus position, direction, step pulse and sticky error registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {STATE_CNT_BITS{1'b0}};
      dir_lat_r   <= 1'b0;
      position_r  <= {POS_BITS{1'b0}};
      step_seen_r <= 1'b0;
      dir_r       <= 1'b0;
      err_r       <= 3'b000;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      dir_lat_r   <= dir_lat_nx_s;
      step_seen_r <= step_rise_s;
      err_r       <= (clr_err ? 3'b000 : err_r) | err_set_s;
      if (step_rise_s) begin
        dir_r <= dir_lvl_s;
      end
      if (set_pos) begin
        position_r <= pos_val;
      end else if (step_rise_s) begin
        position_r <= (dir_lvl_s == DIR_NEG) ? position_r - POS_BITS'(1)
                                             : position_r + POS_BITS'(1);
      end
    end
  end

  assign position  = position_r;
  assign step_seen = step_seen_r;
  assign dir       = dir_r;
  assign err       = err_r;

`ifdef STEP_DIR_DECODER_INTERVAL_EN
  logic [INT_BITS-1:0] int_cnt_r, int_inc_s, interval_r;
  logic                interval_vld_r;

  assign int_inc_s = (int_cnt_r == {INT_BITS{1'b1}}) ? int_cnt_r : int_cnt_r + INT_BITS'(1);

  // cycles since the previous rise, latched into interval on each new rise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_cnt_r      <= {INT_BITS{1'b0}};
      interval_r     <= {INT_BITS{1'b0}};
      interval_vld_r <= 1'b0;
    end else begin
      interval_vld_r <= step_rise_s;
      if (step_rise_s) begin
        interval_r <= int_inc_s;
        int_cnt_r  <= {INT_BITS{1'b0}};
      end else begin
        int_cnt_r  <= int_inc_s;
      end
    end
  end

  assign interval     = interval_r;
  assign interval_vld = interval_vld_r;
`else
  assign interval     = {INT_BITS{1'b0}};
  assign interval_vld = 1'b0;
`endif

endmodule
